// File: rtl/gsim_result_buffer_if.sv
// Stream bundle for gsim_result_buffer: solver-side input burst (no backpressure)
// and bus-side valid/ready output with a frame-end marker.
interface gsim_result_buffer_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16
);
   logic             in_valid;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_last;

   modport master (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_last
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last
   );
endinterface

// File: rtl/gsim_result_buffer.sv
// Captures one Gauss-Seidel solution burst, rounds/saturates each word, then replays
// the frame over valid/ready. Define GSIM_RESULT_CHECKSUM_EN for a trailing checksum beat.
module gsim_result_buffer #(
   parameter int DEPTH = 16,
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   gsim_result_buffer_if.master bus,
   output logic                 busy,
   output logic [4:0]           sat_cnt,
   output logic                 overrun,
   input  logic                 err_clr
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef GSIM_RESULT_CHECKSUM_EN
   localparam int LAST_IDX = DEPTH;
`else
   localparam int LAST_IDX = DEPTH - 1;
`endif
   localparam int RW = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;

   localparam logic signed [IN_W:0] RND   = (IN_W + 1)'(1) <<< (SHIFT - 1);
   localparam logic signed [IN_W:0] R_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [IN_W:0] R_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
   localparam logic [OUT_W-1:0]     SAT_POS = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic [OUT_W-1:0]     SAT_NEG = {1'b1, {(OUT_W - 1){1'b0}}};

   typedef enum logic [0:0] {FILL, DRAIN} state_t;

   state_t           state_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [RW-1:0]    rd_ptr_reg;
   logic             out_valid_reg;
   logic             out_last_reg;
   logic             busy_reg;
   logic [4:0]       sat_cnt_reg;
   logic             overrun_reg;
   logic [OUT_W-1:0] out_data_reg;
`ifdef GSIM_RESULT_CHECKSUM_EN
   logic [OUT_W-1:0] checksum_reg;
`endif

   logic [OUT_W-1:0] mem [DEPTH];

   logic signed [IN_W:0] conv_t;
   logic signed [IN_W:0] conv_r;
   logic [OUT_W-1:0]     conv_word;
   logic                 conv_sat;

   // Round half toward +inf, then clamp to the signed output range.
   always_comb begin
      conv_t    = $signed({bus.in_data[IN_W-1], bus.in_data}) + RND;
      conv_r    = conv_t >>> SHIFT;
      conv_sat  = 1'b0;
      conv_word = conv_r[OUT_W-1:0];
      if (conv_r > R_MAX) begin
         conv_word = SAT_POS;
         conv_sat  = 1'b1;
      end else if (conv_r < R_MIN) begin
         conv_word = SAT_NEG;
         conv_sat  = 1'b1;
      end
   end

   logic             wr_last;
   logic             first_wr;
   logic [4:0]       sat_base;
   logic [RW-1:0]    rd_next;
   logic [OUT_W-1:0] next_word;

   assign wr_last  = (wr_ptr_reg == AW'(DEPTH - 1));
   assign first_wr = (wr_ptr_reg == '0);
   assign sat_base = first_wr ? 5'd0 : sat_cnt_reg;
   assign rd_next  = rd_ptr_reg + 1'b1;

`ifdef GSIM_RESULT_CHECKSUM_EN
   assign next_word = (rd_next == RW'(DEPTH)) ? checksum_reg : mem[rd_next[AW-1:0]];
`else
   assign next_word = mem[rd_next[AW-1:0]];
`endif

   always_ff @(posedge clk) begin
      if (state_reg == FILL && bus.in_valid) begin
         mem[wr_ptr_reg] <= conv_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= FILL;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         sat_cnt_reg   <= 5'd0;
         overrun_reg   <= 1'b0;
         out_data_reg  <= '0;
`ifdef GSIM_RESULT_CHECKSUM_EN
         checksum_reg  <= '0;
`endif
      end else begin
         if (err_clr) begin
            overrun_reg <= 1'b0;
         end
         case (state_reg)
            FILL: begin
               if (bus.in_valid) begin
                  wr_ptr_reg  <= wr_last ? '0 : wr_ptr_reg + 1'b1;
                  sat_cnt_reg <= (conv_sat && sat_base != 5'd31) ? sat_base + 5'd1 : sat_base;
`ifdef GSIM_RESULT_CHECKSUM_EN
                  checksum_reg <= (first_wr ? '0 : checksum_reg) + conv_word;
`endif
                  if (wr_last) begin
                     // mem[0] was written in an earlier cycle, so it is safe to pre-load here.
                     state_reg     <= DRAIN;
                     rd_ptr_reg    <= '0;
                     out_valid_reg <= 1'b1;
                     busy_reg      <= 1'b1;
                     out_last_reg  <= (LAST_IDX == 0);
                     out_data_reg  <= mem[0];
                  end
               end
            end
            DRAIN: begin
               // Set after the clear so a coincident drop still flags.
               if (bus.in_valid) begin
                  overrun_reg <= 1'b1;
               end
               if (bus.out_ready) begin
                  if (out_last_reg) begin
                     state_reg     <= FILL;
                     rd_ptr_reg    <= '0;
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     busy_reg      <= 1'b0;
                  end else begin
                     rd_ptr_reg    <= rd_next;
                     out_last_reg  <= (rd_next == RW'(LAST_IDX));
                     out_data_reg  <= next_word;
                  end
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_last  = out_last_reg;
   assign busy          = busy_reg;
   assign sat_cnt       = sat_cnt_reg;
   assign overrun       = overrun_reg;
endmodule

// File: tb/tb_gsim_result_buffer.sv
// Directed + randomized bench for gsim_result_buffer against a frame-level model.
module tb_gsim_result_buffer;
   localparam int DEPTH = 16;
   localparam int IN_W  = 32;
   localparam int OUT_W = 16;
   localparam int SHIFT = 8;
`ifdef GSIM_RESULT_CHECKSUM_EN
   localparam int BEATS = DEPTH + 1;
`else
   localparam int BEATS = DEPTH;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       err_clr;
   logic       busy;
   logic [4:0] sat_cnt;
   logic       overrun;

   gsim_result_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   gsim_result_buffer #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .busy    (busy),
      .sat_cnt (sat_cnt),
      .overrun (overrun),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] frame [DEPTH];
   logic [15:0] exp_q [$];
   int          exp_sat;
   bit          exp_ovr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Real-number view: value/2^SHIFT rounded half up, clamped to the output range.
   function automatic logic [16:0] model_conv(input logic [31:0] w);
      longint      v;
      longint      r;
      logic [15:0] o;
      v = longint'($signed(w));
      r = (v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (r > 32767)  return {1'b1, 16'h7FFF};
      if (r < -32768) return {1'b1, 16'h8000};
      o = r[15:0];
      return {1'b0, o};
   endfunction

   task automatic load_expect();
      logic [16:0] c;
`ifdef GSIM_RESULT_CHECKSUM_EN
      logic [15:0] sum = 16'h0;
`endif
      exp_q.delete();
      exp_sat = 0;
      for (int i = 0; i < DEPTH; i++) begin
         c = model_conv(frame[i]);
         exp_q.push_back(c[15:0]);
         if (c[16] && exp_sat < 31) exp_sat++;
`ifdef GSIM_RESULT_CHECKSUM_EN
         sum = sum + c[15:0];
`endif
      end
`ifdef GSIM_RESULT_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
   endtask

   // Feeds the frame (optionally with idle gaps); returns at the negedge after the 16th capture.
   task automatic feed(input bit gaps);
      load_expect();
      for (int i = 0; i < DEPTH; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
               chk("fill_valid", bus.out_valid, 0);
               chk("fill_busy", busy, 0);
            end
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = frame[i];
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("latency_valid", bus.out_valid, 1);
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random. Stops when `keep` beats remain.
   task automatic drain(input int mode, input int inj_cycle, input bit inj_last, input int keep);
      int cyc = 0;
      bit rdy;
      while (exp_q.size() > keep && cyc < 400) begin
         chk("busy", busy, 1);
         chk("out_valid", bus.out_valid, 1);
         chk("out_data", bus.out_data, exp_q[0]);
         chk("out_last", bus.out_last, exp_q.size() == 1);
         chk("sat_cnt", sat_cnt, exp_sat);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3) == 0;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bus.out_ready = rdy;
         bus.in_valid  = (cyc == inj_cycle) || (inj_last && rdy && exp_q.size() == 1);
         bus.in_data   = $urandom;
         if (bus.in_valid) exp_ovr = 1'b1;
         if (rdy) void'(exp_q.pop_front());
         cyc++;
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk("overrun", overrun, exp_ovr);
      end
      if (exp_q.size() > keep) chk("drain_timeout", exp_q.size(), keep);
      bus.out_ready = 1'b0;
      if (keep == 0) begin
         chk("end_valid", bus.out_valid, 0);
         chk("end_busy", busy, 0);
      end
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_ovr = 1'b0;
      chk("err_clr", overrun, 0);
   endtask

   task automatic random_frame();
      for (int i = 0; i < DEPTH; i++) begin
         if ($urandom_range(0, 3) == 0) frame[i] = $urandom;
         else frame[i] = 32'($urandom_range(0, 32'h00FFFFFF)) - 32'h00800000;
      end
   endtask

   initial begin
      reset         = 1'b1;
      err_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      exp_ovr       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat", sat_cnt, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_data", bus.out_data, 0);
      reset = 1'b0;

      // Conversion vector
      frame[0] = 32'h00018000; frame[1] = 32'h00000080;
      frame[2] = 32'hFFFFFF80; frame[3] = 32'hFFFE8000;
      for (int i = 4; i < DEPTH; i++) frame[i] = 32'h00010000;
      feed(1'b0);
      drain(0, -1, 1'b0, 0);

      // Saturation
      frame[0] = 32'h7FFF0000; frame[1] = 32'h80000000;
      for (int i = 2; i < DEPTH; i++) frame[i] = 32'h0;
      feed(1'b0);
      drain(0, -1, 1'b0, 0);

      // Backpressure with gapped input
      random_frame();
      feed(1'b1);
      drain(1, -1, 1'b0, 0);

      // Overrun in the 3rd DRAIN cycle, then clear
      random_frame();
      feed(1'b0);
      drain(2, 2, 1'b0, 0);
      clear_err();

      // Overrun coincident with the final handshake
      random_frame();
      feed(1'b1);
      drain(0, -1, 1'b1, 0);
      clear_err();

      // Reset after 5 beats
      random_frame();
      feed(1'b0);
      drain(0, -1, 1'b0, BEATS - 5);
      reset = 1'b1;
      #1;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_sat", sat_cnt, 0);
      @(negedge clk);
      reset   = 1'b0;
      exp_ovr = 1'b0;
      for (int i = 0; i < DEPTH; i++) frame[i] = 32'h00020000;
      feed(1'b0);
      drain(0, -1, 1'b0, 0);

      // Unit words (checksum 0x1000 when enabled)
      for (int i = 0; i < DEPTH; i++) frame[i] = 32'h00010000;
      feed(1'b1);
      drain(1, -1, 1'b0, 0);

      for (int n = 0; n < 6; n++) begin
         random_frame();
         feed(1'($urandom_range(0, 1)));
         drain(2, -1, 1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gsim_result_buffer.md
Name: gsim_result_buffer

Overview:
- Downstream stage of the Gauss-Seidel solver core. Captures the 16-word Q16.16 solution burst, which the core emits with no backpressure.
- Converts each word to a rounded, saturated fixed-point format on capture.
- Replays the frame to the system bus over a valid/ready handshake.
- Decouples the solver's free-running output burst from a stallable consumer.

Parameters:
- DEPTH, 16: words per frame; equals solver vector length.
- IN_W, 32: input word width (signed Q16.16).
- OUT_W, 16: output word width (signed).
- SHIFT, 8: arithmetic right shift applied on conversion. Default yields Q8.8 output.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present; driven by the solver's out_valid.
- in_data  input  IN_W  signed solution word; driven by the solver's x_out.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  OUT_W  converted word.
- out_last  output  1  marks the final beat of a frame.
- busy  output  1  high in DRAIN.
- sat_cnt  output  5  number of saturated words in the current or last frame.
- overrun  output  1  sticky flag: input word dropped.
- err_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values:
  - state=FILL, wr_ptr=0, rd_ptr=0.
  - out_valid=0, out_last=0, busy=0, sat_cnt=0, overrun=0, out_data=0.
  - Buffer contents are don't-care.
- States:
  - FILL:
    - Each cycle with in_valid=1 writes the converted word to buf[wr_ptr] and increments wr_ptr.
    - Gaps in in_valid are tolerated (non-contiguous input is legal).
    - On the write with wr_ptr==DEPTH-1: next state is DRAIN, wr_ptr wraps to 0, rd_ptr=0.
  - DRAIN:
    - out_valid=1 and busy=1.
    - out_data=buf[rd_ptr]; out_last=1 when rd_ptr==DEPTH-1.
    - Handshake transfers on out_valid&&out_ready, which advances rd_ptr.
    - While stalled, out_data and out_last are held stable.
    - Transfer with out_last=1: next state is FILL, out_valid drops next cycle.
- Latency: out_valid rises the cycle after the 16th input word is captured. With out_ready held high, 16 beats follow on consecutive cycles.
- Conversion, done on the write path:
  - t = sign-extend(in_data) to IN_W+1 bits, plus 2^(SHIFT-1).
  - r = t >>> SHIFT (arithmetic shift; round half toward +inf).
  - If r > 2^(OUT_W-1)-1, store 0x7FFF. If r < -2^(OUT_W-1), store 0x8000. Otherwise store r[OUT_W-1:0].
  - Each clamp increments sat_cnt, saturating at 31.
- sat_cnt clears on the first write of a new frame (FILL with wr_ptr==0 and in_valid=1). It holds its value through DRAIN.
- Overrun:
  - in_valid=1 while in DRAIN: the word is dropped and overrun is set.
  - This includes the cycle of the final handshake, because state is still DRAIN in that cycle.
  - overrun clears only on err_clr or reset. If err_clr and a new overrun event coincide, set wins.
- out_ready is ignored outside DRAIN.
- Reset mid-frame discards all captured or pending data immediately. No partial frame is ever emitted.

Optional Feature:
- Macro: GSIM_RESULT_CHECKSUM_EN.
- When defined:
  - A 17th beat follows the 16 data beats.
  - Its out_data is the modulo-2^OUT_W sum of the 16 stored words.
  - out_last moves to this checksum beat; rd_ptr counts to DEPTH.
  - The checksum register accumulates on write and clears with sat_cnt.
- When undefined:
  - Exactly DEPTH beats; out_last on beat DEPTH-1.
  - No checksum logic is present.

Test Plan:
- Conversion vector (SHIFT=8), with out_ready=1:
  - Inputs: 0x00018000, 0x00000080, 0xFFFFFF80, 0xFFFE8000, and 12×0x00010000.
  - Required out_data: 0x0180, 0x0001, 0x0000, 0xFE80, then 12×0x0100.
  - out_last on beat 16; sat_cnt=0.
- Saturation: inputs 0x7FFF0000, 0x80000000, then 14×0 → out_data 0x7FFF, 0x8000, then 14×0x0000; sat_cnt=2.
- Backpressure:
  - 16 words captured, then out_ready toggled 1,0,0,1,...
  - Required: each beat held stable while stalled; exactly 16 transfers in order; busy=1 throughout DRAIN.
- Overrun:
  - in_valid pulsed in the 3rd DRAIN cycle → overrun=1, and drained data unchanged.
  - err_clr pulse → overrun=0.
  - in_valid coincident with the final handshake → word dropped, overrun=1.
- Reset mid-operation:
  - reset asserted after 5 beats drained → out_valid=0 that same cycle (asynchronous).
  - Next burst of 16×0x00020000 → 16×0x0200 with sat_cnt=0.
- With GSIM_RESULT_CHECKSUM_EN defined:
  - 16×0x00010000 → 16×0x0100, then checksum beat 0x1000 carrying out_last.
  - Without the macro: out_last on beat 16.
